// File: rtl/md4_digest_collector_if.sv
// Byte-in / digest-out bundle between the md4 core, the digest collector and its consumer.
// MD4_DIGEST_COMPARE_EN adds the target digest and match flag.
interface md4_digest_collector_if #(
  parameter int HASH_SIZE = 16,
  parameter int CNT_W     = 5
);
  localparam int DIGEST_W = 8 * HASH_SIZE;

  logic                clear;
  logic [7:0]          hash_byte;
  logic                hash_write;
  logic                hash_full;
  logic [DIGEST_W-1:0] digest;
  logic                digest_valid;
  logic                digest_ack;
  logic [CNT_W-1:0]    byte_count;
  logic                overrun;
`ifdef MD4_DIGEST_COMPARE_EN
  logic [DIGEST_W-1:0] target;
  logic                match;
`endif

`ifdef MD4_DIGEST_COMPARE_EN
  modport master (
    output clear, hash_byte, hash_write, digest_ack, target,
    input  hash_full, digest, digest_valid, byte_count, overrun, match
  );
  modport slave (
    input  clear, hash_byte, hash_write, digest_ack, target,
    output hash_full, digest, digest_valid, byte_count, overrun, match
  );
`else
  modport master (
    output clear, hash_byte, hash_write, digest_ack,
    input  hash_full, digest, digest_valid, byte_count, overrun
  );
  modport slave (
    input  clear, hash_byte, hash_write, digest_ack,
    output hash_full, digest, digest_valid, byte_count, overrun
  );
`endif
endinterface

// File: rtl/md4_digest_collector.sv
// Collects the md4 byte-serial hash stream into one digest word held behind valid/ack.
// MD4_DIGEST_COMPARE_EN adds a registered compare against a target digest.
module md4_digest_collector #(
  parameter int HASH_SIZE = 16,
  parameter int CNT_W     = 5
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  md4_digest_collector_if.slave bus
);
  // state   | meaning
  // COLLECT | accepting bytes, full low
  // HOLD    | complete digest held, full and valid high until ack
  localparam int DIGEST_W = 8 * HASH_SIZE;
  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_HOLD    = 1'b1;

  logic [0:0]          r_state;
  logic [DIGEST_W-9:0] r_shift;
  logic [DIGEST_W-1:0] r_digest;
  logic [CNT_W-1:0]    r_count;
  logic                r_overrun;

  logic [DIGEST_W-1:0] w_next_shift;
  logic                w_last;
  logic                w_complete;

  // shift only keeps the earlier bytes; the newest byte completes the word
  assign w_next_shift = {r_shift, bus.hash_byte};
  assign w_last       = (r_count == CNT_W'(HASH_SIZE - 1));
  assign w_complete   = (r_state == ST_COLLECT) && bus.hash_write && w_last && !bus.clear;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_COLLECT;
      r_shift   <= '0;
      r_digest  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else if (bus.clear) begin
      r_state   <= ST_COLLECT;
      r_shift   <= '0;
      r_digest  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (bus.hash_write) begin
            r_shift <= w_next_shift[DIGEST_W-9:0];
            if (w_last) begin
              r_digest <= w_next_shift;
              r_count  <= CNT_W'(HASH_SIZE);
              r_state  <= ST_HOLD;
            end else begin
              r_count <= r_count + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          // bytes arriving while full, including the ack cycle, are dropped
          if (bus.hash_write) r_overrun <= 1'b1;
          if (bus.digest_ack) begin
            r_count <= '0;
            r_state <= ST_COLLECT;
          end
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

`ifdef MD4_DIGEST_COMPARE_EN
  logic r_match;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_match <= 1'b0;
    end else if (bus.clear) begin
      r_match <= 1'b0;
    end else if (w_complete) begin
      r_match <= (w_next_shift == bus.target);
    end else if ((r_state == ST_HOLD) && bus.digest_ack) begin
      r_match <= 1'b0;
    end
  end

  assign bus.match = r_match;
`endif

  assign bus.digest       = r_digest;
  assign bus.digest_valid = (r_state == ST_HOLD);
  assign bus.hash_full    = (r_state == ST_HOLD);
  assign bus.byte_count   = r_count;
  assign bus.overrun      = r_overrun;
endmodule

// File: tb/tb_md4_digest_collector.sv
// Randomised and directed bench for md4_digest_collector against a byte-queue reference model.
// Match checks are active when MD4_DIGEST_COMPARE_EN is defined for the build.
module tb_md4_digest_collector;
  localparam int HASH_SIZE = 16;
  localparam int CNT_W     = 5;
  localparam int DIGEST_W  = 8 * HASH_SIZE;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  md4_digest_collector_if #(.HASH_SIZE(HASH_SIZE), .CNT_W(CNT_W)) bus ();

  md4_digest_collector #(.HASH_SIZE(HASH_SIZE), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: bytes of the digest in progress plus the held result
  byte unsigned        m_q[$];
  logic [DIGEST_W-1:0] m_digest;
  logic                m_valid;
  logic                m_overrun;
  logic                m_match;

  function automatic logic [DIGEST_W-1:0] pack_bytes(input byte unsigned q[$], input logic [7:0] last);
    logic [DIGEST_W-1:0] d;
    d = '0;
    for (int i = 0; i < q.size(); i++) d[DIGEST_W-1-8*i -: 8] = q[i];
    d[DIGEST_W-1-8*q.size() -: 8] = last;
    return d;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_digest  = '0;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
    m_match   = 1'b0;
  endtask

  task automatic model_step(input logic clr, input logic wr, input logic [7:0] b,
                            input logic ack, input logic [DIGEST_W-1:0] tgt);
    if (clr) begin
      model_reset();
    end else if (!m_valid) begin
      if (wr) begin
        if (m_q.size() == HASH_SIZE - 1) begin
          m_digest = pack_bytes(m_q, b);
          m_valid  = 1'b1;
          m_match  = (m_digest == tgt);
          m_q.delete();
        end else begin
          m_q.push_back(b);
        end
      end
    end else begin
      if (wr) m_overrun = 1'b1;
      if (ack) begin
        m_valid = 1'b0;
        m_match = 1'b0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [DIGEST_W-1:0] got, input logic [DIGEST_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_all(input string tag);
    int exp_cnt;
    exp_cnt = m_valid ? HASH_SIZE : m_q.size();
    check({tag, ".digest"},  bus.digest, m_digest);
    check({tag, ".valid"},   DIGEST_W'(bus.digest_valid), DIGEST_W'(m_valid));
    check({tag, ".full"},    DIGEST_W'(bus.hash_full), DIGEST_W'(m_valid));
    check({tag, ".count"},   DIGEST_W'(bus.byte_count), DIGEST_W'(exp_cnt));
    check({tag, ".overrun"}, DIGEST_W'(bus.overrun), DIGEST_W'(m_overrun));
`ifdef MD4_DIGEST_COMPARE_EN
    check({tag, ".match"},   DIGEST_W'(bus.match), DIGEST_W'(m_match));
`endif
  endtask

  function automatic logic [DIGEST_W-1:0] cur_target();
`ifdef MD4_DIGEST_COMPARE_EN
    return bus.target;
`else
    return '0;
`endif
  endfunction

  task automatic set_target(input logic [DIGEST_W-1:0] t);
`ifdef MD4_DIGEST_COMPARE_EN
    bus.target = t;
`else
    if (t != '0) n_checks = n_checks;
`endif
  endtask

  // one clock: drive inputs, advance model on the edge, sample 1 time unit later
  task automatic cycle(input string tag, input logic wr, input logic [7:0] b,
                       input logic ack, input logic clr);
    logic [DIGEST_W-1:0] tgt;
    bus.hash_write = wr;
    bus.hash_byte  = b;
    bus.digest_ack = ack;
    bus.clear      = clr;
    tgt = cur_target();
    @(posedge clk);
    model_step(clr, wr, b, ack, tgt);
    #1;
    check_all(tag);
  endtask

  task automatic send_stream(input string tag, input logic [DIGEST_W-1:0] d, input int gap);
    logic [DIGEST_W-1:0] v;
    v = d;
    for (int i = 0; i < HASH_SIZE; i++) begin
      cycle(tag, 1'b1, v[DIGEST_W-1 -: 8], 1'b0, 1'b0);
      v = v << 8;
      for (int g = 0; g < gap; g++) cycle(tag, 1'b0, 8'h00, 1'b0, 1'b0);
    end
  endtask

  localparam logic [DIGEST_W-1:0] REF_DIGEST = 128'h2baa0645e8c33c14022716e6da14b81c;
  localparam logic [DIGEST_W-1:0] SEQ_DIGEST = 128'h000102030405060708090a0b0c0d0e0f;

  initial begin
    logic [DIGEST_W-1:0] v;
    logic                wr, ack, clr;
    logic [7:0]          b;
    n_checks = 0;
    n_pass   = 0;
    bus.clear      = 1'b0;
    bus.hash_byte  = 8'h00;
    bus.hash_write = 1'b0;
    bus.digest_ack = 1'b0;
    set_target('0);
    model_reset();
    rst_n = 1'b0;
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // reference stream, matching target
    set_target(REF_DIGEST);
    send_stream("ref", REF_DIGEST, 0);
    check("ref_digest", bus.digest, REF_DIGEST);
    check("ref_count", DIGEST_W'(bus.byte_count), DIGEST_W'(16));
`ifdef MD4_DIGEST_COMPARE_EN
    check("ref_match", DIGEST_W'(bus.match), DIGEST_W'(1));
`endif
    cycle("ref_hold", 1'b0, 8'h00, 1'b1, 1'b0);

    // same stream, target differs in the last byte
    set_target({REF_DIGEST[DIGEST_W-1:8], 8'h1d});
    send_stream("nomatch", REF_DIGEST, 0);
    check("nomatch_valid", DIGEST_W'(bus.digest_valid), DIGEST_W'(1));
`ifdef MD4_DIGEST_COMPARE_EN
    check("nomatch_match", DIGEST_W'(bus.match), DIGEST_W'(0));
`endif

    // overrun in HOLD, then ack keeps the sticky flag
    cycle("ovr_byte", 1'b1, 8'hff, 1'b0, 1'b0);
    check("ovr_flag", DIGEST_W'(bus.overrun), DIGEST_W'(1));
    check("ovr_digest", bus.digest, REF_DIGEST);
    cycle("ovr_ack", 1'b0, 8'h00, 1'b1, 1'b0);
    check("ack_count", DIGEST_W'(bus.byte_count), DIGEST_W'(0));
    check("ack_overrun", DIGEST_W'(bus.overrun), DIGEST_W'(1));

    // gapped writes
    send_stream("gap", SEQ_DIGEST, 2);
    check("gap_digest", bus.digest, SEQ_DIGEST);
    cycle("gap_ack_with_byte", 1'b1, 8'h55, 1'b1, 1'b0);

    // partial stream, then clear with a write
    v = REF_DIGEST;
    for (int i = 0; i < 7; i++) begin
      cycle("partial", 1'b1, v[DIGEST_W-1 -: 8], 1'b0, 1'b0);
      v = v << 8;
    end
    cycle("clear", 1'b1, 8'haa, 1'b0, 1'b1);
    check("clear_overrun", DIGEST_W'(bus.overrun), DIGEST_W'(0));
    set_target(SEQ_DIGEST);
    send_stream("post_clear", SEQ_DIGEST, 0);
    check("post_clear_digest", bus.digest, SEQ_DIGEST);
    cycle("post_clear_ack", 1'b0, 8'h00, 1'b1, 1'b0);

    // asynchronous reset mid-stream
    v = REF_DIGEST;
    for (int i = 0; i < 9; i++) begin
      cycle("pre_rst", 1'b1, v[DIGEST_W-1 -: 8], 1'b0, 1'b0);
      v = v << 8;
    end
    bus.hash_write = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    rst_n = 1'b1;
    set_target(REF_DIGEST);
    send_stream("post_rst", REF_DIGEST, 0);
    check("post_rst_digest", bus.digest, REF_DIGEST);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      wr  = ($urandom_range(0, 3) != 0);
      b   = 8'($urandom);
      ack = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 199) == 0);
      if (!m_valid && wr && m_q.size() == HASH_SIZE - 1) begin
        if ($urandom_range(0, 1) == 1) set_target(pack_bytes(m_q, b));
        else set_target({$urandom, $urandom, $urandom, $urandom});
      end
      cycle("rand", wr, b, ack, clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/md4_digest_collector.md
Name: md4_digest_collector

Overview:
- Downstream stage of the md4 core; consumes the byte-serial hash stream from the core's OUTPUT_BYTE/OUTPUT_WRITE port.
- Assembles the bytes into one 128-bit digest word and holds it for a word-wide consumer behind a valid/ack handshake.
- Optionally compares the assembled digest against a target digest and flags a match, for password-recovery loops.
- Sits between the md4 core and the control/result logic, replacing bench-style byte capture.

Parameters:
HASH_SIZE  16  digest length in bytes; DIGEST_W = 8*HASH_SIZE (128 at default)
CNT_W  5  byte counter width; must hold 0..HASH_SIZE

Ports:
CLK  in  1  clock; all state updates on rising edge
RESET_N  in  1  asynchronous, active-low reset
CLEAR_IN  in  1  synchronous flush of partial/held digest
HASH_BYTE_IN  in  8  hash byte from md4 OUTPUT_BYTE
HASH_WRITE_IN  in  1  byte strobe from md4 OUTPUT_WRITE; one byte per high cycle
HASH_FULL_OUT  out  1  high = cannot accept bytes; drives md4 OUTPUT_FULL
DIGEST_OUT  out  DIGEST_W  assembled digest; first received byte in [DIGEST_W-1:DIGEST_W-8]
DIGEST_VALID_OUT  out  1  DIGEST_OUT holds a complete digest
DIGEST_ACK_IN  in  1  consumer takes digest
BYTE_COUNT_OUT  out  CNT_W  bytes collected for the current digest
OVERRUN_OUT  out  1  sticky: byte strobed while full
TARGET_IN  in  DIGEST_W  reference digest (MD4_DIGEST_COMPARE_EN only)
MATCH_OUT  out  1  digest equals TARGET_IN (MD4_DIGEST_COMPARE_EN only)

Behaviour:
- Clock and reset: one clock, CLK. RESET_N is asynchronous and active-low.
- Reset values: every output is 0, and state is COLLECT. This holds for DIGEST_OUT, DIGEST_VALID_OUT, HASH_FULL_OUT, BYTE_COUNT_OUT, OVERRUN_OUT and MATCH_OUT.
- Reset mid-operation clears everything immediately, including a partial or held digest.
- State COLLECT:
  - HASH_FULL_OUT = 0.
  - On HASH_WRITE_IN = 1: shift register <= {shift[DIGEST_W-9:0], HASH_BYTE_IN}, and BYTE_COUNT_OUT increments.
  - When the write is byte HASH_SIZE (count was HASH_SIZE-1):
    - DIGEST_OUT loads the completed value.
    - DIGEST_VALID_OUT = 1 and HASH_FULL_OUT = 1 after the same edge; latency from last byte strobe is 1 edge.
    - BYTE_COUNT_OUT = HASH_SIZE.
    - Go to HOLD.
  - DIGEST_ACK_IN is ignored in COLLECT.
- State HOLD:
  - DIGEST_OUT is stable; HASH_FULL_OUT = 1; DIGEST_VALID_OUT = 1.
  - HASH_WRITE_IN = 1 sets OVERRUN_OUT. The byte is dropped and DIGEST_OUT is unchanged.
  - On DIGEST_ACK_IN = 1:
    - DIGEST_VALID_OUT, HASH_FULL_OUT, BYTE_COUNT_OUT and MATCH_OUT go to 0 after the edge.
    - Go to COLLECT.
    - A byte strobed in the ack cycle is an overrun; it is not accepted.
  - DIGEST_OUT keeps its last value until the next completion.
- CLEAR_IN (priority over write and ack):
  - Zeroes the shift register, DIGEST_OUT, BYTE_COUNT_OUT, DIGEST_VALID_OUT, OVERRUN_OUT and MATCH_OUT.
  - Goes to COLLECT.
  - A byte strobed in the same cycle is discarded.
- OVERRUN_OUT stays high until CLEAR_IN or reset; acks do not clear it.
- Byte order matches the standard MD4 hex string: byte 0 is the leftmost hex pair.

Optional Feature:
- Macro: MD4_DIGEST_COMPARE_EN.
- Defined:
  - TARGET_IN and MATCH_OUT exist.
  - MATCH_OUT is registered on the completing byte edge from the completed value and TARGET_IN sampled in that cycle. It is valid exactly while DIGEST_VALID_OUT = 1.
  - MATCH_OUT clears on ack, clear and reset.
- Undefined: both ports are absent and no comparator is synthesised.

Test Plan:
- Compare mode, stream 2b aa 06 45 e8 c3 3c 14 02 27 16 e6 da 14 b8 1c, one byte per cycle, TARGET_IN = 0x2baa0645e8c33c14022716e6da14b81c:
  - Required: DIGEST_OUT = 0x2baa0645e8c33c14022716e6da14b81c; VALID and FULL high 1 edge after byte 16; BYTE_COUNT_OUT = 16; MATCH_OUT = 1.
- Same stream, target with its last byte 0x1d -> MATCH_OUT = 0, VALID = 1.
- In HOLD, strobe byte 0xff -> OVERRUN_OUT = 1 and DIGEST_OUT unchanged; ack -> VALID = 0, FULL = 0, count 0, OVERRUN_OUT still 1.
- Gapped writes (strobe every 3rd cycle) of bytes 00..0f -> DIGEST_OUT = 0x000102030405060708090a0b0c0d0e0f after byte 16 only.
- 7 bytes in, then CLEAR_IN together with a write strobe -> count 0, VALID = 0, OVERRUN_OUT = 0; a following full stream yields the correct digest.
- RESET_N low mid-stream (after 9 bytes) -> all outputs 0 immediately; a fresh 16-byte stream after release gives the correct digest.
